// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Stall-side companion of the EX-stage forwarding network. Detects the RAW
// hazards that bypassing cannot cover (load-use bubble, operands of in-flight
// long-latency ops, WAW against in-flight long ops, long-unit capacity) and
// freezes PC / IF_ID while injecting a bubble into ID/EX.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   IF_ID_valid/rs1/rs2/use_rs*   instruction in ID and the sources it reads
//   IF_ID_rd/RegWrite/Long        ID destination, write enable, long-op flag
//   ID_EX_rd/MemRead              load currently in EX
//   done_valid/done_rd            long-op writeback this cycle
//   PCWrite/IF_ID_Write           0 freezes PC / IF_ID
//   ID_EX_Flush                   1 inserts a bubble into ID/EX
//   stall_cause                   00 none, 01 load-use, 10 scoreboard, 11 full
//   sb_err                        sticky protocol error (bad done_valid)
//   stall_count                   stall cycle counter
//
// Optional feature: define HAZARD_STATS_EN to build the saturating stall
// counter; otherwise stall_count is tied to zero.
module hazard_scoreboard #(
  parameter int MAX_LONG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_valid,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic        IF_ID_use_rs1,
  input  logic        IF_ID_use_rs2,
  input  logic [4:0]  IF_ID_rd,
  input  logic        IF_ID_RegWrite,
  input  logic        IF_ID_Long,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_MemRead,
  input  logic        done_valid,
  input  logic [4:0]  done_rd,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Flush,
  output logic [1:0]  stall_cause,
  output logic        sb_err,
  output logic [31:0] stall_count
);

  localparam logic [3:0] MaxLong = 4'(MAX_LONG);

  typedef enum logic [1:0] {RUN, LU_STALL, SB_STALL} state_t;

  // Bit 0 of the pending mask is kept at zero so x0 can never block.
  logic [31:0] r_pend;
  logic [3:0]  r_outst;
  state_t      r_state;
  logic        r_sbErr;

  logic [31:0] w_clr, w_eff, w_pendNext;
  logic        w_loadUse, w_sbHaz, w_fullHaz, w_stall, w_issue;
  logic        w_doneErr, w_doneOk;
  logic [1:0]  w_cause;
  logic [3:0]  w_outstNext;

  // Hazard detection. A writeback in this cycle clears its pending bit
  // combinationally because the write-first regfile bypasses the value.
  always_comb begin
    w_clr = '0;
    if (done_valid && done_rd != 5'd0) w_clr[done_rd] = 1'b1;
    w_eff = r_pend & ~w_clr;

    w_loadUse = ID_EX_MemRead && (ID_EX_rd != 5'd0) && IF_ID_valid &&
                ((IF_ID_use_rs1 && ID_EX_rd == IF_ID_rs1) ||
                 (IF_ID_use_rs2 && ID_EX_rd == IF_ID_rs2));

    w_sbHaz = IF_ID_valid &&
              ((IF_ID_use_rs1 && w_eff[IF_ID_rs1]) ||
               (IF_ID_use_rs2 && w_eff[IF_ID_rs2]) ||
               (IF_ID_RegWrite && IF_ID_rd != 5'd0 && w_eff[IF_ID_rd]));

    // Any writeback this cycle frees a unit slot, so a full unit still issues.
    w_fullHaz = IF_ID_valid && IF_ID_Long && (r_outst == MaxLong) && !done_valid;

    w_stall = w_loadUse || w_sbHaz || w_fullHaz;

    if (w_loadUse)     w_cause = 2'b01;
    else if (w_sbHaz)  w_cause = 2'b10;
    else if (w_fullHaz) w_cause = 2'b11;
    else               w_cause = 2'b00;
  end

  // Pipeline control outputs; reset holds the front end frozen.
  always_comb begin
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      stall_cause = 2'b00;
    end else begin
      PCWrite     = ~w_stall;
      IF_ID_Write = ~w_stall;
      ID_EX_Flush = w_stall;
      stall_cause = w_cause;
    end
  end

  // Next scoreboard state. A writeback with nothing outstanding, or for a
  // register that is not pending, is a protocol error and leaves state alone.
  // When issue and writeback hit the same register the issue's set wins.
  always_comb begin
    w_issue   = IF_ID_valid && !w_stall;
    w_doneErr = done_valid &&
                ((r_outst == 4'd0) || (done_rd != 5'd0 && !r_pend[done_rd]));
    w_doneOk  = done_valid && !w_doneErr;

    w_pendNext = r_pend;
    if (w_doneOk) w_pendNext[done_rd] = 1'b0;
    if (w_issue && IF_ID_Long && IF_ID_RegWrite) w_pendNext[IF_ID_rd] = 1'b1;
    w_pendNext[0] = 1'b0;

    w_outstNext = r_outst;
    if ((w_issue && IF_ID_Long) && !w_doneOk)      w_outstNext = r_outst + 4'd1;
    else if (!(w_issue && IF_ID_Long) && w_doneOk) w_outstNext = r_outst - 4'd1;
  end

  // Scoreboard registers, observational FSM and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_outst <= 4'd0;
      r_state <= RUN;
      r_sbErr <= 1'b0;
    end else begin
      r_pend  <= w_pendNext;
      r_outst <= w_outstNext;
      if (w_doneErr) r_sbErr <= 1'b1;
      case (w_cause)
        2'b01:   r_state <= LU_STALL;
        2'b10,
        2'b11:   r_state <= SB_STALL;
        default: r_state <= RUN;
      endcase
    end
  end

  assign sb_err = r_sbErr;

  // The FSM only leaves RUN after a cycle in which the pipeline stalled.
  assert property (@(posedge clk) disable iff (rst) (r_state != RUN) |-> $past(w_stall));

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stallCount;

  // Saturating count of stalled cycles outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
    end else if (w_stall && r_stallCount != 32'hFFFF_FFFF) begin
      r_stallCount <= r_stallCount + 32'd1;
    end
  end

  assign stall_count = r_stallCount;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard. Each driven cycle pushes its
// hand-computed expected outputs into a queue; a monitor pops one entry per
// cycle on the falling edge and compares it with what the DUT presents.
// Honors HAZARD_STATS_EN for the expected stall_count.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_ID_valid, IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_RegWrite, IF_ID_Long;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, IF_ID_rd, ID_EX_rd, done_rd;
  logic        ID_EX_MemRead, done_valid;
  logic        PCWrite, IF_ID_Write, ID_EX_Flush, sb_err;
  logic [1:0]  stall_cause;
  logic [31:0] stall_count;

  typedef struct {
    string       name;
    logic        inReset;
    logic [1:0]  cause;
    logic        sbErr;
    logic [31:0] count;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] expCount = 32'd0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.MAX_LONG(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_valid(IF_ID_valid), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .IF_ID_rd(IF_ID_rd), .IF_ID_RegWrite(IF_ID_RegWrite), .IF_ID_Long(IF_ID_Long),
    .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead),
    .done_valid(done_valid), .done_rd(done_rd),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
    .stall_cause(stall_cause), .sb_err(sb_err), .stall_count(stall_count)
  );

  task automatic setIdle();
    IF_ID_valid = 1'b0; IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0;
    IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0; IF_ID_rd = 5'd0;
    IF_ID_RegWrite = 1'b0; IF_ID_Long = 1'b0;
    ID_EX_rd = 5'd0; ID_EX_MemRead = 1'b0;
    done_valid = 1'b0; done_rd = 5'd0;
  endtask

  task automatic setId(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic wr, input logic lng);
    IF_ID_valid = 1'b1; IF_ID_rs1 = rs1; IF_ID_use_rs1 = u1;
    IF_ID_rs2 = rs2; IF_ID_use_rs2 = u2; IF_ID_rd = rd;
    IF_ID_RegWrite = wr; IF_ID_Long = lng;
  endtask

  task automatic setLoad(input logic [4:0] rd);
    ID_EX_MemRead = 1'b1; ID_EX_rd = rd;
  endtask

  task automatic setDone(input logic [4:0] rd);
    done_valid = 1'b1; done_rd = rd;
  endtask

  // Queue the expectation for the current cycle, then advance one cycle.
  // Counter model: the value seen this cycle counts stalls of earlier cycles;
  // a reset edge clears it.
  task automatic applyStimulus(input string name, input logic [1:0] cause, input logic err);
    exp_t e;
    e.name = name; e.inReset = rst; e.cause = cause; e.sbErr = err;
`ifdef HAZARD_STATS_EN
    e.count = expCount;
`else
    e.count = 32'd0;
`endif
    expQ.push_back(e);
    if (rst) expCount = 32'd0;
    else if (cause != 2'b00) expCount = expCount + 32'd1;
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic checkField(input string n, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    logic expPc, expFlush;
    expPc    = e.inReset ? 1'b0 : (e.cause == 2'b00);
    expFlush = e.inReset ? 1'b1 : (e.cause != 2'b00);
    checkField({e.name, " stall_cause"}, 32'(stall_cause), 32'(e.cause));
    checkField({e.name, " PCWrite"}, 32'(PCWrite), 32'(expPc));
    checkField({e.name, " IF_ID_Write"}, 32'(IF_ID_Write), 32'(expPc));
    checkField({e.name, " ID_EX_Flush"}, 32'(ID_EX_Flush), 32'(expFlush));
    checkField({e.name, " sb_err"}, 32'(sb_err), 32'(e.sbErr));
    checkField({e.name, " stall_count"}, stall_count, e.count);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    setIdle();
    repeat (2) @(posedge clk);
    #1;

    // Reset holds the front end frozen regardless of hazards
    applyStimulus("reset idle", 2'b00, 1'b0);
    setLoad(5); setId(0, 0, 5, 1, 0, 0, 0);
    applyStimulus("reset overrides load-use", 2'b00, 1'b0);
    rst = 1'b0;
    applyStimulus("idle after reset", 2'b00, 1'b0);

    // Load-use bubble
    setLoad(5); setId(0, 0, 5, 1, 1, 1, 0);
    applyStimulus("load-use rs2", 2'b01, 1'b0);
    setId(0, 0, 5, 1, 1, 1, 0);
    applyStimulus("load-use released", 2'b00, 1'b0);
    setLoad(5); setId(5, 0, 5, 0, 1, 1, 0);
    applyStimulus("load sources unused", 2'b00, 1'b0);
    setLoad(0); setId(0, 1, 0, 1, 2, 1, 0);
    applyStimulus("load to x0", 2'b00, 1'b0);

    // Long op to x7 followed by a reader; writeback four cycles later
    setId(0, 0, 0, 0, 7, 1, 1);
    applyStimulus("issue long x7", 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      setId(7, 1, 0, 0, 8, 1, 0);
      applyStimulus("x7 raw stall", 2'b10, 1'b0);
    end
    setId(7, 1, 0, 0, 8, 1, 0); setDone(7);
    applyStimulus("x7 done bypass", 2'b00, 1'b0);
    setId(7, 1, 0, 0, 8, 1, 0);
    applyStimulus("x7 cleared", 2'b00, 1'b0);

    // Long unit capacity
    for (int r = 10; r < 14; r++) begin
      setId(0, 0, 0, 0, 5'(r), 1, 1);
      applyStimulus("fill long unit", 2'b00, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      setId(0, 0, 0, 0, 14, 1, 1);
      applyStimulus("long unit full", 2'b11, 1'b0);
    end
    setId(0, 0, 0, 0, 14, 1, 1); setDone(10);
    applyStimulus("full with same-cycle done", 2'b00, 1'b0);
    setId(0, 0, 0, 0, 15, 1, 1);
    applyStimulus("still full after swap", 2'b11, 1'b0);
    setId(11, 1, 0, 0, 15, 1, 1);
    applyStimulus("scoreboard over full", 2'b10, 1'b0);
    for (int r = 11; r < 15; r++) begin
      setDone(5'(r));
      applyStimulus("drain long unit", 2'b00, 1'b0);
    end
    setId(0, 0, 0, 0, 15, 1, 1);
    applyStimulus("long after drain", 2'b00, 1'b0);
    setDone(15);
    applyStimulus("done x15", 2'b00, 1'b0);

    // WAW against pending x9, priority, and x0 handling
    setId(0, 0, 0, 0, 9, 1, 1);
    applyStimulus("issue long x9", 2'b00, 1'b0);
    setId(0, 0, 0, 0, 9, 1, 0);
    applyStimulus("waw x9", 2'b10, 1'b0);
    setLoad(9); setId(9, 1, 0, 0, 9, 1, 0);
    applyStimulus("load-use over scoreboard", 2'b01, 1'b0);
    setId(0, 0, 0, 0, 9, 1, 0);
    applyStimulus("waw x9 again", 2'b10, 1'b0);
    setId(0, 0, 0, 0, 9, 1, 0); setDone(9);
    applyStimulus("waw released by done", 2'b00, 1'b0);
    setId(0, 0, 0, 0, 0, 1, 1);
    applyStimulus("long to x0", 2'b00, 1'b0);
    setId(0, 1, 0, 1, 0, 1, 0);
    applyStimulus("x0 never pending", 2'b00, 1'b0);
    setDone(0);
    applyStimulus("done x0 decrements", 2'b00, 1'b0);
    applyStimulus("no error after x0 done", 2'b00, 1'b0);

    // Sticky protocol error
    setDone(3);
    applyStimulus("done x3 not pending", 2'b00, 1'b0);
    applyStimulus("sb_err raised", 2'b00, 1'b1);
    setLoad(4); setId(4, 1, 0, 0, 5, 1, 0);
    applyStimulus("sb_err sticky load-use", 2'b01, 1'b1);
    setId(0, 0, 0, 0, 20, 1, 1);
    applyStimulus("sb_err sticky issue", 2'b00, 1'b1);
    setDone(20);
    applyStimulus("sb_err sticky done", 2'b00, 1'b1);
    setId(0, 0, 0, 0, 21, 1, 1);
    applyStimulus("issue long x21", 2'b00, 1'b1);

    // Reset mid-operation discards x21; its late writeback is an error
    rst = 1'b1;
    applyStimulus("reset cycle keeps old err", 2'b00, 1'b1);
    applyStimulus("reset clears err", 2'b00, 1'b0);
    rst = 1'b0;
    setId(21, 1, 0, 0, 22, 1, 0);
    applyStimulus("x21 discarded", 2'b00, 1'b0);
    setDone(21);
    applyStimulus("late done after reset", 2'b00, 1'b0);
    applyStimulus("late done raises err", 2'b00, 1'b1);

    begin
      int budget = 20;
      while (expQ.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
    end
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Stall-side companion of the EX-stage forwarding logic. It sits between IF/ID and ID/EX and resolves every RAW hazard that bypassing cannot cover: the load-use bubble, and operands produced by long-latency units such as multi-cycle mul/div. It tracks in-flight long-op destinations in a register scoreboard and drives PC/IF_ID write-enables plus an ID/EX bubble.

## Interface
- `MAX_LONG`, 4, max outstanding long-latency ops (1..15)
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `IF_ID_valid` input 1 — ID holds a real instruction
- `IF_ID_rs1`, `IF_ID_rs2` input 5 each — ID source registers
- `IF_ID_use_rs1`, `IF_ID_use_rs2` input 1 each — source actually read
- `IF_ID_rd` input 5 — ID destination
- `IF_ID_RegWrite` input 1 — ID instruction writes `rd`
- `IF_ID_Long` input 1 — ID instruction goes to a long-latency unit
- `ID_EX_rd` input 5, `ID_EX_MemRead` input 1 — load currently in EX
- `done_valid` input 1, `done_rd` input 5 — long-op writeback this cycle
- `PCWrite` output 1, `IF_ID_Write` output 1 — 0 freezes PC / IF_ID
- `ID_EX_Flush` output 1 — 1 inserts bubble into ID/EX
- `stall_cause` output 2 — 00 none, 01 load-use, 10 scoreboard, 11 long-unit full
- `sb_err` output 1 — sticky protocol error
- `stall_count` output 32 — stall cycles (see Configuration)

## Operation
- State: `pend[31:1]` mask, `outst` counter (0..MAX_LONG), FSM `RUN`/`LU_STALL`/`SB_STALL`, `sb_err`.
- `clr[r]` = `done_valid && done_rd==r && r!=0`; effective mask `eff = pend & ~clr` (writeback same-cycle bypass through write-first regfile).
- Load-use: `ID_EX_MemRead && ID_EX_rd!=0 && IF_ID_valid && ((use_rs1 && ID_EX_rd==rs1) || (use_rs2 && ID_EX_rd==rs2))`.
- Scoreboard hazard: `IF_ID_valid` and (used source with `eff` bit set, or `IF_ID_RegWrite && rd!=0 && eff[rd]` — WAW).
- Full hazard: `IF_ID_valid && IF_ID_Long && outst==MAX_LONG` and no same-cycle `done_valid`.
- Priority for `stall_cause`: load-use > scoreboard > full. `stall` = any hazard.
- `PCWrite = IF_ID_Write = ~stall`; `ID_EX_Flush = stall`.
- Issue = `IF_ID_valid && !stall`. On issue with `IF_ID_Long && IF_ID_RegWrite && rd!=0`: set `pend[rd]`; on issue with `IF_ID_Long`: `outst+1`.
- `done_valid`: clear `pend[done_rd]`, `outst-1`. Same-cycle issue+done: set wins for same register; `outst` unchanged.
- `done_valid` with `outst==0` or with `done_rd` not pending (rd≠0): ignored for state, `sb_err` set until reset.
- x0 never pending; `done_rd==0` only decrements `outst`.
- FSM next state: `LU_STALL` if cause 01, `SB_STALL` if cause 10/11, else `RUN`; state is observational, stall decision is combinational.

## Timing
- Stall outputs combinational from registered state and current-cycle inputs; zero-cycle latency.
- Load-use stall lasts exactly 1 cycle (load advances to MEM).
- Scoreboard stall releases in the cycle `done_valid` for the blocking register is high.
- Mask/counter update on rising edge after issue/done.
- During `rst`: `PCWrite=0`, `IF_ID_Write=0`, `ID_EX_Flush=1`, `stall_cause=00`. After reset edge: `pend=0`, `outst=0`, FSM `RUN`, `sb_err=0`, `stall_count=0`.
- Reset mid-operation discards all pending entries; late `done_valid` after reset raises `sb_err`.

## Configuration
- `HAZARD_STATS_EN` defined: `stall_count` increments every cycle `stall=1` (not in reset), saturates at 0xFFFFFFFF.
- Undefined: no counter logic; `stall_count` tied to 0.

## Test plan
- Load x5 in EX, ID reads x5 via rs2 -> one cycle `PCWrite=0`, `ID_EX_Flush=1`, cause 01; next cycle no stall.
- Issue long op to x7, next ID reads x7; `done_valid` x7 four cycles later -> stall cause 10 for 3 cycles, released in done cycle.
- Four long ops issued (MAX_LONG=4), fifth long in ID -> cause 11; same-cycle `done_valid` -> issues, `outst` stays 4.
- Long op to x9 pending, ID writes x9 (WAW) -> cause 10 until done x9; op writing x0 -> never pending, no stall.
- `done_valid` x3 with x3 not pending -> `sb_err=1`, stays after further traffic, cleared only by `rst`.
- With `HAZARD_STATS_EN`: 1 load-use + 3 scoreboard stalls -> `stall_count=4`; without macro reads 0.
